// File: rtl/detector_jogada_if.sv
// rtl/detector_jogada_if.sv - move request / accepted-move handshake between controller and detector
`timescale 1ns/1ps
interface detector_jogada_if;
    logic       jogar_macro;
    logic       jogar_micro;
    logic [8:0] botoes;
    logic       tem_jogada;
    logic [3:0] posicao;
    logic [2:0] db_estado;

    modport master (
        output jogar_macro,
        output jogar_micro,
        output botoes,
        input  tem_jogada,
        input  posicao,
        input  db_estado
    );

    modport slave (
        input  jogar_macro,
        input  jogar_micro,
        input  botoes,
        output tem_jogada,
        output posicao,
        output db_estado
    );
endinterface

// File: rtl/detector_jogada.sv
// rtl/detector_jogada.sv - synchronizes and debounces nine buttons into single-cycle move events
`timescale 1ns/1ps
module detector_jogada #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              clock,
    input  logic              reset,
    detector_jogada_if.slave  bus
);
    localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        INATIVO        = 3'd0,
        OCIOSO         = 3'd1,
        DEBOUNCE       = 3'd2,
        EMITE          = 3'd3,
        AGUARDA_SOLTAR = 3'd4
    } estado_t;

    estado_t       estado;
    estado_t       estado_next;
    logic [8:0]    sync1;
    logic [8:0]    bs;
    logic [8:0]    capturado;
    logic [8:0]    capturado_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [3:0]    posicao;
    logic [3:0]    posicao_next;
    logic [3:0]    indice;
    logic          habilitado;
    logic          bs_zero;
    logic          bs_onehot;
    logic          cnt_fim;

    assign habilitado = bus.jogar_macro | bus.jogar_micro;
    assign bs_zero    = (bs == 9'd0);
    assign bs_onehot  = !bs_zero && ((bs & (bs - 9'd1)) == 9'd0);
    assign cnt_fim    = (cnt == CNT_LAST);

    always_comb begin
        indice = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (capturado[i]) begin
                indice = 4'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1     <= 9'd0;
            bs        <= 9'd0;
            estado    <= INATIVO;
            cnt       <= '0;
            capturado <= 9'd0;
            posicao   <= 4'd0;
        end else begin
            sync1     <= bus.botoes;
            bs        <= sync1;
            estado    <= estado_next;
            cnt       <= cnt_next;
            capturado <= capturado_next;
            posicao   <= posicao_next;
        end
    end

    always_comb begin
        estado_next    = estado;
        cnt_next       = cnt;
        capturado_next = capturado;
        posicao_next   = posicao;
        case (estado)
            INATIVO: begin
                // a button still down from a previous phase must be released first
                if (habilitado) begin
                    if (bs_zero) begin
                        estado_next = OCIOSO;
                    end else begin
                        estado_next = AGUARDA_SOLTAR;
                        cnt_next    = '0;
                    end
                end
            end
            OCIOSO: begin
                if (!habilitado) begin
                    estado_next = INATIVO;
                end else if (bs_onehot) begin
                    estado_next    = DEBOUNCE;
                    capturado_next = bs;
                    cnt_next       = '0;
                end else if (!bs_zero) begin
                    estado_next = AGUARDA_SOLTAR;
                    cnt_next    = '0;
                end
            end
            DEBOUNCE: begin
                if (!habilitado) begin
                    estado_next = INATIVO;
                end else if (bs != capturado) begin
                    estado_next = OCIOSO;
                end else if (cnt_fim) begin
                    estado_next  = EMITE;
                    posicao_next = indice;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            EMITE: begin
                estado_next = AGUARDA_SOLTAR;
                cnt_next    = '0;
            end
            AGUARDA_SOLTAR: begin
                if (!bs_zero) begin
                    cnt_next = '0;
                end else if (cnt_fim) begin
                    estado_next = INATIVO;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                estado_next = INATIVO;
            end
        endcase
    end

    assign bus.tem_jogada = (estado == EMITE);
    assign bus.posicao    = posicao;
    assign bus.db_estado  = estado;
endmodule

// File: tb/tb_detector_jogada.sv
// tb/tb_detector_jogada.sv - bench for detector_jogada with directed scenarios and a run-length reference model
`timescale 1ns/1ps
module tb_detector_jogada;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    detector_jogada_if bus();

    detector_jogada #(.DEBOUNCE_CYCLES(N)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference: phase + run length of stable samples, two-sample input delay queue
    int         ph = 0;
    int         run = 0;
    int         m_pos = 0;
    logic [8:0] cand = 9'd0;
    logic [8:0] pipe[$] = '{9'd0, 9'd0};
    logic       e_tem = 1'b0;
    logic [3:0] e_pos = 4'd0;
    logic [2:0] e_est = 3'd0;

    task automatic model_step(input bit r, input bit hab, input logic [8:0] raw);
        logic [8:0] b;
        b = pipe[0];
        if (r) begin
            ph = 0; run = 0; cand = 9'd0; m_pos = 0;
            pipe = '{9'd0, 9'd0};
        end else begin
            pipe.push_back(raw);
            void'(pipe.pop_front());
            case (ph)
                0: if (hab) begin ph = (b == 9'd0) ? 1 : 4; run = 0; end
                1: begin
                    if (!hab) ph = 0;
                    else if ($countones(b) == 1) begin ph = 2; cand = b; run = 1; end
                    else if (b != 9'd0) begin ph = 4; run = 0; end
                end
                2: begin
                    if (!hab) ph = 0;
                    else if (b != cand) ph = 1;
                    else if (run == N) begin ph = 3; m_pos = $clog2(cand); end
                    else run++;
                end
                3: begin ph = 4; run = 0; end
                default: begin
                    if (b != 9'd0) run = 0;
                    else begin run++; if (run == N) ph = 0; end
                end
            endcase
        end
        e_tem = (ph == 3);
        e_pos = 4'(m_pos);
        e_est = 3'(ph);
    endtask

    task automatic step(input bit r, input bit mac, input bit mic, input logic [8:0] b);
        rst             = r;
        bus.jogar_macro = mac;
        bus.jogar_micro = mic;
        bus.botoes      = b;
        @(posedge clk);
        model_step(r, mac | mic, b);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 9'h1FF);
        step(1, 0, 0, 9'h1FF);
        n_cmp++;
        if ({bus.tem_jogada, bus.posicao, bus.db_estado} !== 8'd0) begin
            n_bad++;
            $display("FAIL reset: got tem=%b pos=%0d est=%0d, want 0/0/0", bus.tem_jogada, bus.posicao, bus.db_estado);
        end
        step(0, 0, 0, 9'h000);
        n_cmp++;
        if (bus.db_estado !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_idle: got est=%0d, want 0", bus.db_estado);
        end
    endtask

    task automatic test_single_press();
        int pulses = 0;
        int pulse_at = -1;
        step(1, 0, 0, 9'h000);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 9'h000);
        for (int k = 0; k < 20; k++) begin
            step(0, 1, 0, 9'h010);
            n_cmp++;
            if ({bus.tem_jogada, bus.posicao, bus.db_estado} !== {e_tem, e_pos, e_est}) begin
                n_bad++;
                $display("FAIL single_press k=%0d: got %b/%0d/%0d, want %b/%0d/%0d", k,
                         bus.tem_jogada, bus.posicao, bus.db_estado, e_tem, e_pos, e_est);
            end
            if (bus.tem_jogada) begin pulses++; if (pulse_at < 0) pulse_at = k; end
        end
        n_cmp++;
        if (pulses !== 1 || pulse_at !== N + 2 || bus.posicao !== 4'd4) begin
            n_bad++;
            $display("FAIL single_press_summary: got pulses=%0d at=%0d pos=%0d, want 1 at %0d pos 4",
                     pulses, pulse_at, bus.posicao, N + 2);
        end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        step(1, 0, 0, 9'h000);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 9'h000);
        for (int k = 0; k < 9; k++) begin
            step(0, 1, 0, (k < 3) ? 9'h004 : 9'h000);
            n_cmp++;
            if ({bus.tem_jogada, bus.posicao, bus.db_estado} !== {e_tem, e_pos, e_est}) begin
                n_bad++;
                $display("FAIL glitch k=%0d: got %b/%0d/%0d, want %b/%0d/%0d", k,
                         bus.tem_jogada, bus.posicao, bus.db_estado, e_tem, e_pos, e_est);
            end
            if (bus.tem_jogada) pulses++;
        end
        n_cmp++;
        if (pulses !== 0 || bus.db_estado !== 3'd1 || bus.posicao !== 4'd0) begin
            n_bad++;
            $display("FAIL glitch_summary: got pulses=%0d est=%0d pos=%0d, want 0/1/0", pulses, bus.db_estado, bus.posicao);
        end
    endtask

    task automatic test_multi_button();
        int pair_pulses = 0;
        int pulses = 0;
        step(1, 0, 0, 9'h000);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 9'h000);
        for (int k = 0; k < 25; k++) begin
            step(0, 1, 0, (k < 5) ? 9'h082 : (k < 13) ? 9'h000 : 9'h080);
            n_cmp++;
            if ({bus.tem_jogada, bus.posicao, bus.db_estado} !== {e_tem, e_pos, e_est}) begin
                n_bad++;
                $display("FAIL multi k=%0d: got %b/%0d/%0d, want %b/%0d/%0d", k,
                         bus.tem_jogada, bus.posicao, bus.db_estado, e_tem, e_pos, e_est);
            end
            if (bus.tem_jogada) begin pulses++; if (k < 13) pair_pulses++; end
        end
        n_cmp++;
        if (pair_pulses !== 0 || pulses !== 1 || bus.posicao !== 4'd7) begin
            n_bad++;
            $display("FAIL multi_summary: got pair=%0d total=%0d pos=%0d, want 0/1/7", pair_pulses, pulses, bus.posicao);
        end
    endtask

    task automatic test_held_over();
        int pulses = 0;
        step(1, 0, 0, 9'h000);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 9'h001);
        for (int k = 0; k < 6; k++) begin
            step(0, 0, 1, 9'h001);
            if (bus.tem_jogada) pulses++;
        end
        n_cmp++;
        if (pulses !== 0 || bus.db_estado !== 3'd4) begin
            n_bad++;
            $display("FAIL held_over: got pulses=%0d est=%0d, want 0/4", pulses, bus.db_estado);
        end
        for (int k = 0; k < 18; k++) begin
            step(0, 0, 1, (k < 8) ? 9'h000 : 9'h001);
            n_cmp++;
            if ({bus.tem_jogada, bus.posicao, bus.db_estado} !== {e_tem, e_pos, e_est}) begin
                n_bad++;
                $display("FAIL held_over k=%0d: got %b/%0d/%0d, want %b/%0d/%0d", k,
                         bus.tem_jogada, bus.posicao, bus.db_estado, e_tem, e_pos, e_est);
            end
            if (bus.tem_jogada) pulses++;
        end
        n_cmp++;
        if (pulses !== 1 || bus.posicao !== 4'd0) begin
            n_bad++;
            $display("FAIL held_over_fresh: got pulses=%0d pos=%0d, want 1/0", pulses, bus.posicao);
        end
    endtask

    task automatic test_disable_mid_debounce();
        int pulses = 0;
        step(1, 0, 0, 9'h000);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 9'h000);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0, 9'h020);
            if (bus.tem_jogada) pulses++;
        end
        step(0, 0, 0, 9'h000);
        n_cmp++;
        if (bus.db_estado !== 3'd0 || bus.tem_jogada !== 1'b0) begin
            n_bad++;
            $display("FAIL disable_mid: got est=%0d tem=%b, want 0/0", bus.db_estado, bus.tem_jogada);
        end
        for (int k = 0; k < 22; k++) begin
            step(0, (k >= 6), 0, (k >= 9 && k < 19) ? 9'h100 : 9'h000);
            n_cmp++;
            if ({bus.tem_jogada, bus.posicao, bus.db_estado} !== {e_tem, e_pos, e_est}) begin
                n_bad++;
                $display("FAIL disable_mid k=%0d: got %b/%0d/%0d, want %b/%0d/%0d", k,
                         bus.tem_jogada, bus.posicao, bus.db_estado, e_tem, e_pos, e_est);
            end
            if (bus.tem_jogada) pulses++;
        end
        n_cmp++;
        if (pulses !== 1 || bus.posicao !== 4'd8) begin
            n_bad++;
            $display("FAIL disable_mid_reenable: got pulses=%0d pos=%0d, want 1/8", pulses, bus.posicao);
        end
    endtask

    task automatic test_reset_in_release();
        step(1, 0, 0, 9'h000);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 9'h000);
        for (int k = 0; k < 12; k++) step(0, 1, 0, 9'h008);
        n_cmp++;
        if (bus.db_estado !== 3'd4 || bus.posicao !== 4'd3) begin
            n_bad++;
            $display("FAIL release_wait: got est=%0d pos=%0d, want 4/3", bus.db_estado, bus.posicao);
        end
        step(1, 1, 0, 9'h008);
        n_cmp++;
        if ({bus.tem_jogada, bus.posicao, bus.db_estado} !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_in_release: got %b/%0d/%0d, want 0/0/0", bus.tem_jogada, bus.posicao, bus.db_estado);
        end
    endtask

    task automatic test_random();
        logic [8:0] pat = 9'd0;
        int         dur = 0;
        bit         mac = 1'b1;
        bit         mic = 1'b0;
        bit         r;
        bit         prev_tem = 1'b0;
        int         pulses = 0;
        int         sel;
        step(1, 0, 0, 9'h000);
        for (int k = 0; k < 4000; k++) begin
            if (dur == 0) begin
                sel = $urandom_range(0, 9);
                if (sel < 3)      pat = 9'd0;
                else if (sel < 8) pat = 9'(1 << $urandom_range(0, 8));
                else              pat = 9'($urandom);
                dur = $urandom_range(1, 2 * N + 3);
            end
            dur--;
            if ($urandom_range(0, 39) == 0) mac = ~mac;
            if ($urandom_range(0, 59) == 0) mic = ~mic;
            r = ($urandom_range(0, 499) == 0);
            step(r, mac, mic, pat);
            n_cmp++;
            if ({bus.tem_jogada, bus.posicao, bus.db_estado} !== {e_tem, e_pos, e_est}) begin
                n_bad++;
                $display("FAIL random k=%0d: got %b/%0d/%0d, want %b/%0d/%0d", k,
                         bus.tem_jogada, bus.posicao, bus.db_estado, e_tem, e_pos, e_est);
            end
            n_cmp++;
            if (prev_tem && bus.tem_jogada) begin
                n_bad++;
                $display("FAIL random_double_pulse k=%0d: got tem=1 twice, want single cycle", k);
            end
            prev_tem = bus.tem_jogada;
            if (bus.tem_jogada) pulses++;
        end
        n_cmp++;
        if (pulses == 0) begin
            n_bad++;
            $display("FAIL random_activity: got 0 pulses, want at least 1");
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_multi_button();
        test_held_over();
        test_disable_mid_debounce();
        test_reset_in_release();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
